// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control/status bundle for the programmable-modulus counter
interface mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, sat, load, load_val, limit,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up, sat, load, load_val, limit,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - programmable-modulus up/down counter with wrap/saturate and cascade carry
module mod_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             ovf_q;

    // Terminal count: the counter is at its range end in the current direction
    // and would roll over on this edge; feeds the next stage's en.
    assign bus.tc = bus.en & ((bus.up & (count_q >= bus.limit)) |
                              (~bus.up & (count_q == '0)));

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;

    // Count state update: reset > load > en > hold; wrap is a one-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.load) begin
            // Loads are clamped into range so the counter never starts above limit.
            count_q <= (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (count_q < bus.limit) begin
                    count_q <= count_q + WIDTH'(1);
                    wrap_q  <= 1'b0;
                end else if (bus.sat) begin
                    count_q <= bus.limit;
                    wrap_q  <= 1'b0;
                    ovf_q   <= 1'b1;
                end else begin
                    count_q <= '0;
                    wrap_q  <= 1'b1;
                    ovf_q   <= 1'b1;
                end
            end else begin
                if (count_q > bus.limit) begin
                    // limit was lowered below the current count: snap down, not an overflow.
                    count_q <= bus.limit;
                    wrap_q  <= 1'b0;
                end else if (count_q != '0) begin
                    count_q <= count_q - WIDTH'(1);
                    wrap_q  <= 1'b0;
                end else if (bus.sat) begin
                    wrap_q  <= 1'b0;
                    ovf_q   <= 1'b1;
                end else begin
                    count_q <= bus.limit;
                    wrap_q  <= 1'b1;
                    ovf_q   <= 1'b1;
                end
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - randomized model-checked bench for mod_counter
module tb_mod_counter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    logic c_reset;
    logic c_en;

    always #5 clk = ~clk;

    mod_counter_if #(.WIDTH(W)) bus ();
    mod_counter_if #(.WIDTH(W)) lo_bus ();
    mod_counter_if #(.WIDTH(W)) hi_bus ();

    mod_counter #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mod_counter #(.WIDTH(W), .RESET_VAL(4'd0)) u_lo (
        .clk   (clk),
        .reset (c_reset),
        .bus   (lo_bus)
    );

    mod_counter #(.WIDTH(W), .RESET_VAL(4'd0)) u_hi (
        .clk   (clk),
        .reset (c_reset),
        .bus   (hi_bus)
    );

    assign lo_bus.en = c_en;
    assign hi_bus.en = lo_bus.tc;

    int vectors    = 0;
    int miscompares = 0;
    bit checking   = 1'b0;

    // Behavioural reference state
    int m_count = 0;
    bit m_wrap  = 1'b0;
    bit m_ovf   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: apply the counting rules to integers at each edge.
    always @(posedge clk) begin
        int lim;
        int ld;
        lim = int'(bus.limit);
        ld  = int'(bus.load_val);
        if (reset) begin
            m_count = 0;
            m_wrap  = 1'b0;
            m_ovf   = 1'b0;
        end else if (bus.load) begin
            m_count = (ld < lim) ? ld : lim;
            m_wrap  = 1'b0;
            m_ovf   = 1'b0;
        end else if (bus.en) begin
            m_wrap = 1'b0;
            if (bus.up) begin
                if (m_count < lim) begin
                    m_count = m_count + 1;
                end else begin
                    m_ovf   = 1'b1;
                    m_wrap  = !bus.sat;
                    m_count = bus.sat ? lim : 0;
                end
            end else begin
                if (m_count > lim) begin
                    m_count = lim;
                end else if (m_count > 0) begin
                    m_count = m_count - 1;
                end else begin
                    m_ovf   = 1'b1;
                    m_wrap  = !bus.sat;
                    m_count = bus.sat ? 0 : lim;
                end
            end
        end else begin
            m_wrap = 1'b0;
        end
    end

    // Compare process: every negedge once reset has been applied.
    always @(negedge clk) begin
        if (checking) begin
            bit exp_tc;
            exp_tc = bus.en && ((bus.up && m_count >= int'(bus.limit)) ||
                                (!bus.up && m_count == 0));
            chk("count", int'(bus.count), m_count);
            chk("wrap",  int'(bus.wrap),  int'(m_wrap));
            chk("ovf",   int'(bus.ovf),   int'(m_ovf));
            chk("tc",    int'(bus.tc),    int'(exp_tc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.sat      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.limit    = 4'd9;
        c_reset      = 1'b1;
        c_en         = 1'b0;
        lo_bus.up = 1'b1; lo_bus.sat = 1'b0; lo_bus.load = 1'b0;
        lo_bus.load_val = '0; lo_bus.limit = 4'd9;
        hi_bus.up = 1'b1; hi_bus.sat = 1'b0; hi_bus.load = 1'b0;
        hi_bus.load_val = '0; hi_bus.limit = 4'd9;

        tick();
        checking = 1'b1;
        tick();
        chk("reset_count", int'(bus.count), 0);
        chk("reset_ovf",   int'(bus.ovf),   0);

        // Wrap mode, counting up through the terminal value
        reset = 1'b0; bus.en = 1'b1; bus.up = 1'b1; bus.sat = 1'b0;
        repeat (9) tick();
        chk("up9_count", int'(bus.count), 9);
        chk("up9_tc",    int'(bus.tc),    1);
        tick();
        chk("wrap_count", int'(bus.count), 0);
        chk("wrap_pulse", int'(bus.wrap),  1);
        chk("wrap_ovf",   int'(bus.ovf),   1);
        tick();
        chk("post_wrap_count", int'(bus.count), 1);
        chk("post_wrap_pulse", int'(bus.wrap),  0);
        chk("post_wrap_ovf",   int'(bus.ovf),   1);

        // Saturate mode from 0
        bus.load = 1'b1; bus.load_val = 4'd0;
        tick();
        bus.load = 1'b0; bus.sat = 1'b1;
        repeat (9) tick();
        chk("sat9_ovf", int'(bus.ovf), 0);
        repeat (3) tick();
        chk("sat_count", int'(bus.count), 9);
        chk("sat_ovf",   int'(bus.ovf),   1);
        chk("sat_wrap",  int'(bus.wrap),  0);

        // Down, wrap mode: 2,1,0,9,8
        bus.sat = 1'b0; bus.load = 1'b1; bus.load_val = 4'd2; bus.en = 1'b0;
        tick();
        chk("load2", int'(bus.count), 2);
        bus.load = 1'b0; bus.up = 1'b0; bus.en = 1'b1;
        tick(); tick();
        chk("down0_count", int'(bus.count), 0);
        chk("down0_tc",    int'(bus.tc),    1);
        tick();
        chk("down_wrap_count", int'(bus.count), 9);
        chk("down_wrap_pulse", int'(bus.wrap),  1);
        tick();
        chk("down8", int'(bus.count), 8);

        // Load above limit clamps; lowered limit snaps count down
        bus.load = 1'b1; bus.load_val = 4'd13;
        tick();
        chk("clamp_load", int'(bus.count), 9);
        chk("clamp_ovf",  int'(bus.ovf),   0);
        bus.load = 1'b0; bus.limit = 4'd5; bus.up = 1'b0; bus.en = 1'b1;
        tick();
        chk("limit_snap", int'(bus.count), 5);
        chk("limit_snap_ovf", int'(bus.ovf), 0);

        // Reset beats load and en
        bus.load = 1'b1; bus.load_val = 4'd7; bus.limit = 4'd9;
        tick();
        bus.load_val = 4'd3; reset = 1'b1;
        tick();
        chk("rst_count", int'(bus.count), 0);
        tick();
        chk("rst_hold", int'(bus.count), 0);
        reset = 1'b0; bus.load = 1'b0; bus.up = 1'b1;
        tick();
        chk("rst_resume", int'(bus.count), 1);

        // limit = 0: stays at 0, wraps every enabled cycle
        bus.limit = 4'd0;
        tick();
        tick();
        chk("lim0_count", int'(bus.count), 0);
        chk("lim0_wrap",  int'(bus.wrap),  1);
        chk("lim0_tc",    int'(bus.tc),    1);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 49) == 0);
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.en       = ($urandom_range(0, 3) != 0);
            bus.up       = $urandom_range(0, 1) != 0;
            bus.sat      = $urandom_range(0, 1) != 0;
            bus.load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0)
                bus.limit = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0;

        // Cascaded pair: 25 enables -> {2,5}
        tick();
        c_reset = 1'b0; c_en = 1'b1;
        repeat (25) tick();
        c_en = 1'b0;
        tick();
        chk("cascade_lo", int'(lo_bus.count), 5);
        chk("cascade_hi", int'(hi_bus.count), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
